// File: rtl/bkm_iter_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bkm_iter_ctrl
// Purpose  : Sequencing controller for the BKM iteration datapath. After it
//            accepts a start request it issues a one-cycle operand-load
//            strobe. It then steps the iteration index n = 0 .. iters_q-1,
//            one value per enabled cycle, and finishes with a one-cycle done
//            pulse.
// Ports    : clk      - clock, rising edge
//            arst     - asynchronous reset, active-high
//            ena      - clock enable; when low, all state and outputs hold
//            start    - begin a sequence (sampled only in IDLE)
//            iters    - requested iteration count, clamped to N_ITER_MAX
//            abort    - (BKM_ITER_CTRL_ABORT_EN only) return to IDLE without
//                       issuing done
//            ready    - controller is idle and can accept start
//            load     - datapath captures operands
//            iter_en  - datapath registers update
//            n        - iteration index for the div_by_2_n shifters
//            last     - final iteration cycle
//            done     - sequence complete
// Params   : LOG2N must match LOG2N of the div_by_2_n instances.
//            N_ITER_MAX must satisfy 1 <= N_ITER_MAX <= 2**LOG2N-1.
// Macro    : BKM_ITER_CTRL_ABORT_EN adds the abort input.
// Revision : 1.0 - initial release
// ============================================================================
module bkm_iter_ctrl #(
  parameter int LOG2N      = 6,
  parameter int N_ITER_MAX = 21
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             ena,
  input  logic             start,
  input  logic [LOG2N-1:0] iters,
`ifdef BKM_ITER_CTRL_ABORT_EN
  input  logic             abort,
`endif
  output logic             ready,
  output logic             load,
  output logic             iter_en,
  output logic [LOG2N-1:0] n,
  output logic             last,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_ITER = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [LOG2N-1:0] C_ITER_MAX = LOG2N'(N_ITER_MAX);
  localparam logic [LOG2N-1:0] C_ONE      = LOG2N'(1);

  state_t           state_q, state_d;
  logic [LOG2N-1:0] n_q, n_d;
  logic [LOG2N-1:0] iters_q, iters_d;
  logic             ready_q, load_q, iter_en_q, last_q, done_q;
  logic             ready_d, load_d, iter_en_d, last_d, done_d;
  logic             abort_req;

`ifdef BKM_ITER_CTRL_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    iters_d = iters_q;
    if (ena) begin
      if (abort_req && (state_q != S_IDLE)) begin
        // Abort takes priority over every other transition outside IDLE.
        state_d = S_IDLE;
        n_d     = '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start) begin
              state_d = S_LOAD;
              iters_d = (iters > C_ITER_MAX) ? C_ITER_MAX : iters;
            end
          end
          S_LOAD: begin
            n_d     = '0;
            state_d = (iters_q != '0) ? S_ITER : S_DONE;
          end
          S_ITER: begin
            if (n_q == iters_q - C_ONE) begin
              state_d = S_DONE;
              n_d     = '0;
            end else begin
              n_d = n_q + C_ONE;
            end
          end
          default: state_d = S_IDLE;   // S_DONE
        endcase
      end
    end

    // The outputs are decoded from the next state and registered. This keeps
    // them glitch-free and in step with state_q and n_q. When ena is low the
    // decode reproduces the current values, so the outputs hold.
    ready_d   = (state_d == S_IDLE);
    load_d    = (state_d == S_LOAD);
    iter_en_d = (state_d == S_ITER);
    done_d    = (state_d == S_DONE);
    last_d    = (state_d == S_ITER) && (n_d == iters_d - C_ONE);
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q   <= S_IDLE;
      n_q       <= '0;
      iters_q   <= '0;
      ready_q   <= 1'b1;
      load_q    <= 1'b0;
      iter_en_q <= 1'b0;
      last_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      iters_q   <= iters_d;
      ready_q   <= ready_d;
      load_q    <= load_d;
      iter_en_q <= iter_en_d;
      last_q    <= last_d;
      done_q    <= done_d;
    end
  end

  assign ready   = ready_q;
  assign load    = load_q;
  assign iter_en = iter_en_q;
  assign n       = n_q;
  assign last    = last_q;
  assign done    = done_q;

endmodule
`default_nettype wire

// File: tb/tb_bkm_iter_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_bkm_iter_ctrl
// Purpose  : Directed self-checking bench for bkm_iter_ctrl. The expected
//            outputs are hand-derived for each cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bkm_iter_ctrl;

  logic       clk = 1'b0;
  logic       arst;
  logic       ena;
  logic       start;
  logic [5:0] iters;
`ifdef BKM_ITER_CTRL_ABORT_EN
  logic       abort;
`endif
  logic       ready, load, iter_en, last, done;
  logic [5:0] n;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  bkm_iter_ctrl #(.LOG2N(6), .N_ITER_MAX(21)) u_dut (
    .clk     (clk),
    .arst    (arst),
    .ena     (ena),
    .start   (start),
    .iters   (iters),
`ifdef BKM_ITER_CTRL_ABORT_EN
    .abort   (abort),
`endif
    .ready   (ready),
    .load    (load),
    .iter_en (iter_en),
    .n       (n),
    .last    (last),
    .done    (done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else
      n_pass++;
  endtask

  // The fields are packed as {ready, load, iter_en, last, done, n[5:0]}.
  task automatic expect_out(input string tag, input bit r, input bit l, input bit ie,
                            input bit la, input bit d, input int nn);
    logic [5:0] nv;
    nv = nn[5:0];
    chk(tag, {21'd0, ready, load, iter_en, last, done, n},
             {21'd0, r, l, ie, la, d, nv});
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    arst  = 1'b1;
    ena   = 1'b1;
    start = 1'b0;
    iters = '0;
`ifdef BKM_ITER_CTRL_ABORT_EN
    abort = 1'b0;
`endif
    #12;
    expect_out("reset", 1, 0, 0, 0, 0, 0);
    tick;
    expect_out("reset_hold", 1, 0, 0, 0, 0, 0);
    arst = 1'b0;
    tick;
    expect_out("idle", 1, 0, 0, 0, 0, 0);

    // iters=5: load, then n=0..4, then done, then ready.
    start = 1'b1; iters = 6'd5;
    tick;
    expect_out("t5_load", 0, 1, 0, 0, 0, 0);
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick;
      expect_out("t5_iter", 0, 0, 1, (i == 4), 0, i);
    end
    tick;
    expect_out("t5_done", 0, 0, 0, 0, 1, 0);
    tick;
    expect_out("t5_ready", 1, 0, 0, 0, 0, 0);

    // iters=0: load, then done directly. Done is stretched while ena is low.
    start = 1'b1; iters = 6'd0;
    tick;
    expect_out("t0_load", 0, 1, 0, 0, 0, 0);
    start = 1'b0;
    tick;
    expect_out("t0_done", 0, 0, 0, 0, 1, 0);
    ena = 1'b0;
    tick;
    tick;
    expect_out("t0_done_hold", 0, 0, 0, 0, 1, 0);
    ena = 1'b1;
    tick;
    expect_out("t0_ready", 1, 0, 0, 0, 0, 0);

    // iters=40 is clamped to 21 iterations.
    start = 1'b1; iters = 6'd40;
    tick;
    expect_out("t40_load", 0, 1, 0, 0, 0, 0);
    start = 1'b0;
    for (int i = 0; i < 21; i++) begin
      tick;
      expect_out("t40_iter", 0, 0, 1, (i == 20), 0, i);
    end
    tick;
    expect_out("t40_done", 0, 0, 0, 0, 1, 0);
    tick;
    expect_out("t40_ready", 1, 0, 0, 0, 0, 0);

    // iters=8: freeze at n=3 for 3 cycles and pulse start during ITER.
    start = 1'b1; iters = 6'd8;
    tick;
    expect_out("t8_load", 0, 1, 0, 0, 0, 0);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick;
      expect_out("t8_iter_a", 0, 0, 1, 0, 0, i);
    end
    ena = 1'b0; start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      expect_out("t8_frozen", 0, 0, 1, 0, 0, 3);
    end
    ena = 1'b1;
    tick;
    expect_out("t8_resume", 0, 0, 1, 0, 0, 4);
    start = 1'b0;
    for (int i = 5; i < 8; i++) begin
      tick;
      expect_out("t8_iter_b", 0, 0, 1, (i == 7), 0, i);
    end
    tick;
    expect_out("t8_done", 0, 0, 0, 0, 1, 0);
    tick;
    expect_out("t8_ready", 1, 0, 0, 0, 0, 0);
    tick;
    expect_out("t8_no_restart", 1, 0, 0, 0, 0, 0);

    // Asynchronous reset between edges while n=2.
    start = 1'b1; iters = 6'd5;
    tick;
    expect_out("rst_load", 0, 1, 0, 0, 0, 0);
    start = 1'b0;
    tick;
    tick;
    tick;
    expect_out("rst_n2", 0, 0, 1, 0, 0, 2);
    #2 arst = 1'b1;
    #1;
    expect_out("rst_async", 1, 0, 0, 0, 0, 0);
    #1 arst = 1'b0;
    tick;
    expect_out("rst_idle1", 1, 0, 0, 0, 0, 0);
    tick;
    expect_out("rst_idle2", 1, 0, 0, 0, 0, 0);
    start = 1'b1; iters = 6'd1;
    tick;
    expect_out("t1_load", 0, 1, 0, 0, 0, 0);
    start = 1'b0;
    tick;
    expect_out("t1_iter", 0, 0, 1, 1, 0, 0);
    tick;
    expect_out("t1_done", 0, 0, 0, 0, 1, 0);
    tick;
    expect_out("t1_ready", 1, 0, 0, 0, 0, 0);

`ifdef BKM_ITER_CTRL_ABORT_EN
    // Abort at n=6 of iters=10.
    start = 1'b1; iters = 6'd10;
    tick;
    expect_out("ab_load", 0, 1, 0, 0, 0, 0);
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick;
      expect_out("ab_iter", 0, 0, 1, 0, 0, i);
    end
    abort = 1'b1;
    tick;
    expect_out("ab_idle", 1, 0, 0, 0, 0, 0);
    abort = 1'b0;
    tick;
    expect_out("ab_no_done", 1, 0, 0, 0, 0, 0);
    // Abort together with start in IDLE still accepts the start.
    abort = 1'b1; start = 1'b1; iters = 6'd2;
    tick;
    expect_out("abst_load", 0, 1, 0, 0, 0, 0);
    abort = 1'b0; start = 1'b0;
    tick;
    expect_out("abst_n0", 0, 0, 1, 0, 0, 0);
    tick;
    expect_out("abst_n1", 0, 0, 1, 1, 0, 1);
    tick;
    expect_out("abst_done", 0, 0, 0, 0, 1, 0);
    tick;
    expect_out("abst_ready", 1, 0, 0, 0, 0, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bkm_iter_ctrl.md
Name: bkm_iter_ctrl

Overview:
- Sequencing controller for the BKM iteration datapath.
- Accepts a start request with an iteration count.
- Emits a one-cycle operand-load strobe, then steps the iteration index n = 0,1,…,iters-1, one value per enabled cycle. n drives the n input of every div_by_2_n shifter in the datapath.
- Signals last iteration and completion to the surrounding FPU.

Parameters:
- LOG2N, 6: width of n and iters. Must match LOG2N of the div_by_2_n instances.
- N_ITER_MAX, 21: maximum iterations executed. Requests above this are clamped. Constraint: 1 ≤ N_ITER_MAX ≤ 2^LOG2N - 1.

Ports:
- clk  in  1  clock, rising edge.
- arst  in  1  asynchronous reset, active-high.
- ena  in  1  clock enable. When 0, all state, n and outputs hold.
- start  in  1  request to begin a sequence. Sampled only in IDLE with ena=1.
- iters  in  LOG2N  requested iteration count, unsigned. Sampled with start.
- ready  out  1  high in IDLE: controller can accept start.
- load  out  1  high for the LOAD cycle: datapath registers capture operands.
- iter_en  out  1  high in ITER: datapath registers update.
- n  out  LOG2N  current iteration index. Unsigned; 0 outside ITER.
- last  out  1  iter_en && (n == iters_q - 1).
- done  out  1  one-cycle pulse in DONE.

Behaviour:
- Interface decided: one clock (clk); reset arst is asynchronous and active-high.
- States: IDLE, LOAD, ITER, DONE. State and n are registered. All outputs are decoded from registered state and n only; no combinational path from inputs to outputs.
- Reset (arst=1, immediate, regardless of clk/ena):
  - state=IDLE, n=0, iters_q=0.
  - ready=1, load=0, iter_en=0, last=0, done=0.
- All transitions below require ena=1. With ena=0 the controller is frozen in its current state, including mid-ITER and DONE; a done pulse stretches until the next enabled edge.
- IDLE:
  - start=1 → LOAD. Capture iters_q = min(iters, N_ITER_MAX).
  - start=0 → stay in IDLE.
- LOAD: n=0 → ITER if iters_q≠0; → DONE if iters_q=0 (no ITER cycles).
- ITER:
  - n < iters_q-1: n ← n+1, stay in ITER.
  - n = iters_q-1: → DONE, n ← 0.
  - n never wraps; the maximum value reached is N_ITER_MAX-1.
- DONE: → IDLE unconditionally.
- start while not in IDLE is ignored. No queuing, no restart.
- Latency: start accepted at edge t → load high in cycle t+1, first iter_en in t+2, done in t+2+iters_q, ready again in t+3+iters_q. With iters_q=0: done in t+2.
- Back-to-back sequences: minimum spacing is iters_q+3 cycles between accepted starts.
- Reset asserted mid-sequence: immediate return to IDLE with reset values; done is not issued.
- Mutual exclusion: ready, load, iter_en and done are one-hot (exactly one high). last implies iter_en.

Optional Feature:
- Macro: BKM_ITER_CTRL_ABORT_EN.
- When defined:
  - Adds input port abort (1 bit).
  - abort=1 with ena=1 in LOAD, ITER or DONE → IDLE on the next edge, n ← 0, no done pulse.
  - abort has priority over all other transitions. abort in IDLE has no effect, and abort together with start in IDLE still accepts start.
- When undefined: no abort port; every accepted sequence runs to DONE unless reset.

Test Plan:
- Reset, then start=1, iters=5, ena=1 → load at t+1; n = 0,1,2,3,4 with iter_en in t+2..t+6; last only at n=4; done at t+7; ready at t+8.
- start with iters=0 → load at t+1, done at t+2, iter_en never high, n stays 0.
- start with iters=40, N_ITER_MAX=21 → exactly 21 ITER cycles, n ends at 20, last at n=20, then done.
- iters=8; drop ena for 3 cycles when n=3, and pulse start=1 during ITER → n holds at 3 for 3 cycles, then resumes; the extra start is ignored; done 3 cycles late.
- Assert arst asynchronously (between edges) while n=2 → outputs immediately return to reset values (ready=1, n=0); no done; a new start is then accepted normally.
- With BKM_ITER_CTRL_ABORT_EN: abort at n=6 of iters=10 → IDLE next edge, no done. Abort+start in IDLE → sequence starts.
